// File: rtl/dac7821_write_sched_if.sv
// Bundle between the CPU address decoder and the DAC7821 write scheduler.
// Carries the one-hot value enables, the CPU data and the shared DAC bus outputs.
// Ports: master = decoder/CPU side (drives WR_EN/DATA_IN); slave = scheduler side.
interface dac7821_write_sched_if #(
    parameter int NCH = 7,
    parameter int DW  = 12
);
    logic [NCH-1:0] WR_EN;     // one-hot write strobes, one cycle per CPU write
    logic [DW-1:0]  DATA_IN;   // CPU data, sampled when any WR_EN bit is high
    logic [DW-1:0]  DAC_DATA;  // shared DAC7821 parallel data bus
    logic [NCH-1:0] DAC_CS_N;  // per-DAC chip select, active low
    logic           DAC_RW_N;  // shared R/W_n, 0 = write
    logic           BUSY;      // transfer in flight or anything pending
    logic [NCH-1:0] DONE;      // one-cycle one-hot completion pulse

    modport master (
        output WR_EN, DATA_IN,
        input  DAC_DATA, DAC_CS_N, DAC_RW_N, BUSY, DONE
    );

    modport slave (
        input  WR_EN, DATA_IN,
        output DAC_DATA, DAC_CS_N, DAC_RW_N, BUSY, DONE
    );
endinterface

// File: rtl/dac7821_write_sched.sv
// Round-robin write scheduler serialising per-DAC shadow values onto one shared DAC7821 bus.
// Latency: grant one edge after capture; grant-to-grant period TSU+TCS+THOLD+1 cycles.
// Backpressure: none toward the CPU; writes coalesce per channel (latest value wins), never dropped.
// Ports: Clock, Reset_n (sync, active low), bus (slave modport: WR_EN/DATA_IN in;
//        DAC_DATA/DAC_CS_N/DAC_RW_N/BUSY/DONE out, all registered).
module dac7821_write_sched #(
    parameter int NCH   = 7,
    parameter int DW    = 12,
    parameter int TSU   = 2,
    parameter int TCS   = 3,
    parameter int THOLD = 1
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    dac7821_write_sched_if.slave bus
);

    localparam int IW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CMAX0 = (TSU > TCS) ? TSU : TCS;
    localparam int CMAX  = (CMAX0 > THOLD) ? CMAX0 : THOLD;
    localparam int CW    = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;        // cycles left in the current phase, minus one
    logic [IW-1:0]  last;       // most recently granted channel
    logic [IW-1:0]  cur;        // channel of the transfer in flight
    logic [NCH-1:0] pending;
    logic [DW-1:0]  shadow [NCH];

    logic [DW-1:0]  dac_data;
    logic [NCH-1:0] dac_cs_n;
    logic           dac_rw_n;
    logic           busy;
    logic [NCH-1:0] done;

    logic           gnt_vld;
    logic [IW-1:0]  gnt_idx;
    logic           do_grant;
    logic           xfer_end;
    logic [NCH-1:0] gnt_clr;
    logic [NCH-1:0] pend_nxt;
    logic           busy_nxt;

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 1; k <= NCH; k++) begin
            if (!gnt_vld && pending[IW'((int'(last) + k) % NCH)]) begin
                gnt_vld = 1'b1;
                gnt_idx = IW'((int'(last) + k) % NCH);
            end
        end
    end

    // A capture in the grant cycle re-sets the flag the grant clears, so no write is lost.
    always_comb begin
        do_grant = (state == IDLE) && gnt_vld;
        xfer_end = (state == HOLD) && (cnt == '0);
        gnt_clr  = do_grant ? (NCH'(1) << gnt_idx) : '0;
        pend_nxt = (pending & ~gnt_clr) | bus.WR_EN;
        busy_nxt = do_grant || ((state != IDLE) && !xfer_end) || (pend_nxt != '0);
    end

    // Shadow values: every enabled channel captures independently.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            for (int i = 0; i < NCH; i++) shadow[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (bus.WR_EN[i]) shadow[i] <= bus.DATA_IN;
            end
        end
    end

    // Transfer FSM; the grant reads the pre-edge shadow so a same-edge write becomes a new transfer.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            last     <= IW'(NCH - 1);
            cur      <= '0;
            pending  <= '0;
            dac_data <= '0;
            dac_cs_n <= '1;
            dac_rw_n <= 1'b1;
            busy     <= 1'b0;
            done     <= '0;
        end else begin
            pending <= pend_nxt;
            busy    <= busy_nxt;
            done    <= '0;
            case (state)
                IDLE: begin
                    if (do_grant) begin
                        dac_data <= shadow[gnt_idx];
                        dac_rw_n <= 1'b0;
                        last     <= gnt_idx;
                        cur      <= gnt_idx;
                        cnt      <= CW'(TSU - 1);
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        dac_cs_n[cur] <= 1'b0;
                        cnt           <= CW'(TCS - 1);
                        state         <= STROBE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STROBE: begin
                    if (cnt == '0) begin
                        dac_cs_n <= '1;
                        cnt      <= CW'(THOLD - 1);
                        state    <= HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        dac_rw_n <= 1'b1;
                        done     <= NCH'(1) << cur;
                        cnt      <= '0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.DAC_DATA = dac_data;
    assign bus.DAC_CS_N = dac_cs_n;
    assign bus.DAC_RW_N = dac_rw_n;
    assign bus.BUSY     = busy;
    assign bus.DONE     = done;

endmodule

// File: tb/tb_dac7821_write_sched.sv
// Bench for dac7821_write_sched: directed timing/ordering scenarios plus random traffic
// compared against a transfer-timeline reference model.
// Outputs are sampled 1 time unit after each rising edge.
module tb_dac7821_write_sched;

    localparam int NCH    = 7;
    localparam int DW     = 12;
    localparam int TSU    = 2;
    localparam int TCS    = 3;
    localparam int THOLD  = 1;
    localparam int PERIOD = TSU + TCS + THOLD + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dac7821_write_sched_if #(.NCH(NCH), .DW(DW)) bus ();

    dac7821_write_sched #(
        .NCH(NCH), .DW(DW), .TSU(TSU), .TCS(TCS), .THOLD(THOLD)
    ) dut (
        .Clock   (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: per-channel latest value and pending flag, plus the start edge of the
    // transfer in flight; outputs follow from the phase offset since the grant.
    logic [DW-1:0]  m_shadow [NCH];
    logic [NCH-1:0] m_pend;
    int             m_last;
    bit             m_act;
    int             m_gstart;
    int             m_gch;
    logic [DW-1:0]  m_data;

    logic [DW-1:0]  e_data;
    logic [NCH-1:0] e_cs;
    logic           e_rw;
    logic           e_busy;
    logic [NCH-1:0] e_done;

    // Observed transfers (one entry per CS_n falling edge).
    int          dut_ch[$];
    logic [11:0] dut_val[$];
    int          dut_edge[$];
    logic [6:0]  prev_cs = 7'h7F;

    task automatic model_edge(input logic rn, input logic [6:0] we, input logic [11:0] d);
        if (!rn) begin
            for (int i = 0; i < NCH; i++) m_shadow[i] = '0;
            m_pend = '0; m_last = NCH - 1; m_act = 0; m_data = '0;
            e_cs = '1; e_rw = 1'b1; e_data = '0; e_busy = 1'b0; e_done = '0;
            return;
        end
        e_done = '0;
        if (m_act && (cyc - m_gstart) == PERIOD - 1) begin
            m_act  = 0;
            e_done = 7'(1) << m_gch;
        end else if (!m_act && m_pend != '0) begin
            bit found = 0;
            for (int k = 1; k <= NCH; k++) begin
                int c = (m_last + k) % NCH;
                if (!found && m_pend[c]) begin
                    found    = 1;
                    m_gch    = c;
                    m_data   = m_shadow[c];
                    m_pend[c] = 1'b0;
                    m_last   = c;
                    m_gstart = cyc;
                    m_act    = 1;
                end
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (we[i]) begin
                m_shadow[i] = d;
                m_pend[i]   = 1'b1;
            end
        end
        if (m_act) begin
            int p = cyc - m_gstart;
            e_rw = 1'b0;
            e_cs = (p >= TSU && p < TSU + TCS) ? ~(7'(1) << m_gch) : 7'h7F;
        end else begin
            e_rw = 1'b1;
            e_cs = 7'h7F;
        end
        e_data = m_data;
        e_busy = m_act || (m_pend != '0);
    endtask

    task automatic tick(input logic rn, input logic [6:0] we, input logic [11:0] d);
        rst_n       = rn;
        bus.WR_EN   = we;
        bus.DATA_IN = d;
        @(posedge clk);
        cyc++;
        model_edge(rn, we, d);
        #1;
        if (bus.DAC_CS_N != 7'h7F && prev_cs == 7'h7F) begin
            int ch = -1;
            for (int i = 0; i < NCH; i++) if (!bus.DAC_CS_N[i]) ch = i;
            dut_ch.push_back(ch);
            dut_val.push_back(bus.DAC_DATA);
            dut_edge.push_back(cyc);
        end
        prev_cs = bus.DAC_CS_N;
    endtask

    task automatic do_reset();
        tick(1'b0, '0, '0);
        tick(1'b0, '0, '0);
        dut_ch.delete(); dut_val.delete(); dut_edge.delete();
    endtask

    task automatic test_reset();
        int n = 0;
        do_reset();
        n_cmp++; if (bus.DAC_CS_N !== 7'h7F) begin n_bad++; $display("FAIL reset_cs got %h want 7f", bus.DAC_CS_N); end
        n_cmp++; if (bus.DAC_RW_N !== 1'b1) begin n_bad++; $display("FAIL reset_rw got %b want 1", bus.DAC_RW_N); end
        n_cmp++; if (bus.DAC_DATA !== 12'h000) begin n_bad++; $display("FAIL reset_data got %h want 000", bus.DAC_DATA); end
        n_cmp++; if (bus.BUSY !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.BUSY); end
        n_cmp++; if (bus.DONE !== 7'h00) begin n_bad++; $display("FAIL reset_done got %h want 00", bus.DONE); end
        // Start a ch4 transfer and abort it in STROBE.
        tick(1'b1, 7'h10, 12'h777);
        while (bus.DAC_CS_N === 7'h7F && n < 10) begin
            tick(1'b1, '0, '0);
            n++;
        end
        n_cmp++; if (bus.DAC_CS_N !== 7'h6F) begin n_bad++; $display("FAIL abort_strobe_reached got %h want 6f", bus.DAC_CS_N); end
        tick(1'b0, '0, '0);
        n_cmp++; if (bus.DAC_CS_N !== 7'h7F) begin n_bad++; $display("FAIL abort_cs got %h want 7f", bus.DAC_CS_N); end
        n_cmp++; if (bus.DAC_RW_N !== 1'b1) begin n_bad++; $display("FAIL abort_rw got %b want 1", bus.DAC_RW_N); end
        n_cmp++; if (bus.DAC_DATA !== 12'h000) begin n_bad++; $display("FAIL abort_data got %h want 000", bus.DAC_DATA); end
        n_cmp++; if (bus.BUSY !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b want 0", bus.BUSY); end
        for (int k = 0; k < 12; k++) begin
            tick(1'b1, '0, '0);
            n_cmp++;
            if (bus.DAC_CS_N !== 7'h7F || bus.DAC_RW_N !== 1'b1 || bus.BUSY !== 1'b0) begin
                n_bad++;
                $display("FAIL abort_no_retry cyc %0d got cs=%h rw=%b busy=%b want 7f/1/0",
                         k, bus.DAC_CS_N, bus.DAC_RW_N, bus.BUSY);
            end
        end
    endtask

    task automatic test_single();
        logic [6:0] xcs;
        logic       xrw;
        logic [6:0] xdone;
        do_reset();
        tick(1'b1, 7'h02, 12'hABC);   // E0
        n_cmp++; if (bus.BUSY !== 1'b1) begin n_bad++; $display("FAIL single_busy_e0 got %b want 1", bus.BUSY); end
        for (int k = 1; k <= 8; k++) begin
            tick(1'b1, '0, '0);
            xcs   = (k >= 3 && k <= 5) ? 7'h7D : 7'h7F;
            xrw   = (k >= 1 && k <= 6) ? 1'b0 : 1'b1;
            xdone = (k == 7) ? 7'h02 : 7'h00;
            n_cmp++; if (bus.DAC_CS_N !== xcs) begin n_bad++; $display("FAIL single_cs E%0d got %h want %h", k, bus.DAC_CS_N, xcs); end
            n_cmp++; if (bus.DAC_RW_N !== xrw) begin n_bad++; $display("FAIL single_rw E%0d got %b want %b", k, bus.DAC_RW_N, xrw); end
            n_cmp++; if (bus.DONE !== xdone) begin n_bad++; $display("FAIL single_done E%0d got %h want %h", k, bus.DONE, xdone); end
            n_cmp++; if (bus.DAC_DATA !== 12'hABC) begin n_bad++; $display("FAIL single_data E%0d got %h want abc", k, bus.DAC_DATA); end
            n_cmp++; if (bus.BUSY !== (k <= 6)) begin n_bad++; $display("FAIL single_busy E%0d got %b want %b", k, bus.BUSY, k <= 6); end
        end
    endtask

    task automatic test_overwrite_repend();
        int t0;
        logic [6:0]  we;
        logic [11:0] d;
        do_reset();
        t0 = cyc + 1;
        for (int t = 0; t <= 30; t++) begin
            we = '0; d = '0;
            case (t)
                0:  begin we = 7'h20; d = 12'h055; end
                1:  begin we = 7'h08; d = 12'h111; end
                2:  begin we = 7'h08; d = 12'h222; end
                11: begin we = 7'h08; d = 12'h333; end
                default: ;
            endcase
            tick(1'b1, we, d);
        end
        n_cmp++; if (dut_ch.size() !== 3) begin n_bad++; $display("FAIL ovw_count got %0d want 3", dut_ch.size()); end
        if (dut_ch.size() >= 3) begin
            n_cmp++; if (dut_ch[1] !== 3 || dut_val[1] !== 12'h222) begin n_bad++; $display("FAIL ovw_first got ch%0d %h want ch3 222", dut_ch[1], dut_val[1]); end
            n_cmp++; if (dut_edge[1] - t0 !== 10) begin n_bad++; $display("FAIL ovw_first_edge got %0d want 10", dut_edge[1] - t0); end
            n_cmp++; if (dut_ch[2] !== 3 || dut_val[2] !== 12'h333) begin n_bad++; $display("FAIL repend got ch%0d %h want ch3 333", dut_ch[2], dut_val[2]); end
            n_cmp++; if (dut_edge[2] - dut_edge[1] !== PERIOD) begin n_bad++; $display("FAIL repend_gap got %0d want %0d", dut_edge[2] - dut_edge[1], PERIOD); end
        end
    endtask

    task automatic test_round_robin();
        int t0;
        logic [11:0] vals [8];
        logic [6:0]  we;
        logic [11:0] d;
        do_reset();
        for (int i = 0; i < 8; i++) vals[i] = 12'($urandom);
        t0 = cyc + 1;
        for (int t = 0; t <= 62; t++) begin
            we = '0; d = '0;
            if (t < NCH) begin we = 7'(1) << t; d = vals[t]; end
            else if (t == 17) begin we = 7'h01; d = vals[7]; end  // during the ch2 transfer
            tick(1'b1, we, d);
        end
        n_cmp++; if (dut_ch.size() !== 8) begin n_bad++; $display("FAIL rr_count got %0d want 8", dut_ch.size()); end
        if (dut_edge.size() > 0) begin
            n_cmp++; if (dut_edge[0] - t0 !== TSU + 1) begin n_bad++; $display("FAIL rr_first_edge got %0d want %0d", dut_edge[0] - t0, TSU + 1); end
        end
        for (int i = 0; i < dut_ch.size() && i < 8; i++) begin
            n_cmp++;
            if (dut_ch[i] !== ((i < NCH) ? i : 0) || dut_val[i] !== vals[i]) begin
                n_bad++;
                $display("FAIL rr_order slot %0d got ch%0d %h want ch%0d %h", i, dut_ch[i], dut_val[i], (i < NCH) ? i : 0, vals[i]);
            end
            if (i > 0) begin
                n_cmp++;
                if (dut_edge[i] - dut_edge[i-1] !== PERIOD) begin
                    n_bad++;
                    $display("FAIL rr_gap slot %0d got %0d want %0d", i, dut_edge[i] - dut_edge[i-1], PERIOD);
                end
            end
        end
    endtask

    task automatic test_grant_collision();
        do_reset();
        tick(1'b1, 7'h04, 12'h5A5);   // capture
        tick(1'b1, 7'h04, 12'hFFF);   // grant edge of ch2
        for (int t = 0; t < 20; t++) tick(1'b1, '0, '0);
        n_cmp++; if (dut_ch.size() !== 2) begin n_bad++; $display("FAIL coll_count got %0d want 2", dut_ch.size()); end
        if (dut_ch.size() >= 2) begin
            n_cmp++; if (dut_ch[0] !== 2 || dut_val[0] !== 12'h5A5) begin n_bad++; $display("FAIL coll_old got ch%0d %h want ch2 5a5", dut_ch[0], dut_val[0]); end
            n_cmp++; if (dut_ch[1] !== 2 || dut_val[1] !== 12'hFFF) begin n_bad++; $display("FAIL coll_new got ch%0d %h want ch2 fff", dut_ch[1], dut_val[1]); end
            n_cmp++; if (dut_edge[1] - dut_edge[0] !== PERIOD) begin n_bad++; $display("FAIL coll_gap got %0d want %0d", dut_edge[1] - dut_edge[0], PERIOD); end
        end
    endtask

    task automatic test_random();
        logic [6:0]  we;
        logic [11:0] d;
        do_reset();
        for (int t = 0; t < 1500; t++) begin
            we = '0;
            d  = 12'($urandom);
            if ($urandom_range(3) == 0) we = 7'(1) << $urandom_range(NCH - 1);
            tick(1'b1, we, d);
            n_cmp++;
            if (bus.DAC_CS_N !== e_cs || bus.DAC_RW_N !== e_rw || bus.DAC_DATA !== e_data ||
                bus.BUSY !== e_busy || bus.DONE !== e_done) begin
                n_bad++;
                $display("FAIL rand_model cyc %0d got cs=%h rw=%b data=%h busy=%b done=%h want cs=%h rw=%b data=%h busy=%b done=%h",
                         t, bus.DAC_CS_N, bus.DAC_RW_N, bus.DAC_DATA, bus.BUSY, bus.DONE,
                         e_cs, e_rw, e_data, e_busy, e_done);
            end
            n_cmp++;
            if ($countones(~bus.DAC_CS_N) > 1) begin
                n_bad++;
                $display("FAIL rand_cs_onehot cyc %0d got %h want at most one low bit", t, bus.DAC_CS_N);
            end
            n_cmp++;
            if (!bus.BUSY && (bus.DAC_CS_N !== 7'h7F || bus.DAC_RW_N !== 1'b1)) begin
                n_bad++;
                $display("FAIL rand_idle cyc %0d got cs=%h rw=%b with busy=0 want 7f/1", t, bus.DAC_CS_N, bus.DAC_RW_N);
            end
        end
    endtask

    initial begin
        bus.WR_EN   = '0;
        bus.DATA_IN = '0;
        test_reset();
        test_single();
        test_overwrite_repend();
        test_round_robin();
        test_grant_collision();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
